// File: rtl/crypto_engine_arbiter.sv
// Round-robin arbiter and sequencer sharing one 8-bit XOR cipher engine between
// NUM_REQ requesters, with a WAIT-state timeout that returns an error response.
module crypto_engine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [8*NUM_REQ-1:0]   req_key,
  input  logic [NUM_REQ-1:0]     req_encrypt,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [7:0]             resp_data,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   eng_start,
  output logic [7:0]             eng_data,
  output logic [7:0]             eng_key,
  output logic                   eng_encrypt,
  input  logic                   eng_done,
  input  logic [7:0]             eng_result
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic             winner_found;
  logic [7:0]       cnt;
  logic [7:0]       result;
  logic             err;
  logic             timed_out;

  assign timed_out = (cnt == CNT_LAST);

  // Search downward from ptr+NUM_REQ to ptr+1 so the last hit, which overrides
  // earlier ones, is the requester closest after the pointer.
  always_comb begin
    logic [IDX_W:0] sum;
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    sum          = '0;
    winner       = '0;
    winner_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (req[sum[IDX_W-1:0]]) begin
        winner       = sum[IDX_W-1:0];
        winner_found = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (winner_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_done || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job context: operands are frozen at the grant edge and held until the next job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      eng_data    <= '0;
      eng_key     <= '0;
      eng_encrypt <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (winner_found) begin
          owner       <= winner;
          eng_data    <= req_data[{winner, 3'b000} +: 8];
          eng_key     <= req_key[{winner, 3'b000} +: 8];
          eng_encrypt <= req_encrypt[winner];
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // A completion in the last allowed cycle still counts as success.
          if (eng_done) begin
            result <= eng_result;
            err    <= 1'b0;
          end else if (timed_out) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: ptr <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt        = '0;
    resp_valid = '0;
    eng_start  = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      ISSUE: begin
        gnt[owner] = 1'b1;
        eng_start  = 1'b1;
      end
      RESP: begin
        resp_valid[owner] = 1'b1;
        resp_data         = result;
        resp_err          = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crypto_engine_arbiter.sv
// Bench for crypto_engine_arbiter: job-level reference model checked every cycle,
// a delay-programmable XOR engine, and directed scenarios with literal expectations.
module tb_crypto_engine_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;
  localparam logic [8*N-1:0] BYTE_MASK = {{(8*N-8){1'b0}}, 8'hFF};

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_encrypt;
  logic [8*N-1:0] req_data, req_key;
  logic [N-1:0]   gnt, resp_valid;
  logic [7:0]     resp_data;
  logic           resp_err, busy, eng_start;
  logic [7:0]     eng_data, eng_key;
  logic           eng_encrypt;
  logic           eng_done   = 1'b0;
  logic [7:0]     eng_result = 8'h00;

  crypto_engine_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_key(req_key),
    .req_encrypt(req_encrypt), .gnt(gnt), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy), .eng_start(eng_start),
    .eng_data(eng_data), .eng_key(eng_key), .eng_encrypt(eng_encrypt),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine: done pulses e_delay cycles after it sees start (0 = never finishes).
  int         e_delay     = 1;
  bit         e_force     = 1'b0;
  logic [7:0] e_force_val = 8'h00;
  int         e_cnt       = 0;
  logic [7:0] e_data      = 8'h00;
  logic [7:0] e_key       = 8'h00;

  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) begin
      eng_done = 1'b0; eng_result = 8'h00; e_cnt = 0;
    end else begin
      eng_done = 1'b0;
      if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = e_force ? e_force_val : (e_data ^ e_key);
        end
      end
      if (eng_start) begin
        e_cnt = e_delay; e_data = eng_data; e_key = eng_key;
      end
    end
  end

  // Reference model: a job is picked in idle, issues at age 0, may finish at
  // ages 2..TO+1, responds one cycle, and frees the arbiter one edge later.
  bit         m_active   = 1'b0;
  int         m_age      = 0;
  int         m_resp_age = 0;
  int         m_ptr      = N - 1;
  int         m_owner    = 0;
  logic [7:0] m_data = '0, m_key = '0, m_res = '0;
  logic       m_enc = 1'b0, m_err = 1'b0;

  function automatic int rr_pick(logic [N-1:0] r, int p);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = r >> ((p + k) % N);
      if (s[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial forever begin
    logic [N-1:0] enc_s;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_resp_age = 0; m_ptr = N - 1; m_owner = 0;
      m_data = '0; m_key = '0; m_enc = 1'b0; m_res = '0; m_err = 1'b0;
    end else begin
      cyc++;
      if (!m_active) begin
        if (req != '0) begin
          m_owner = rr_pick(req, m_ptr);
          m_data  = 8'(req_data >> (8 * m_owner));
          m_key   = 8'(req_key >> (8 * m_owner));
          enc_s   = req_encrypt >> m_owner;
          m_enc   = enc_s[0];
          m_active = 1'b1; m_age = 0; m_resp_age = 0;
        end
      end else begin
        m_age++;
        if (m_resp_age != 0) begin
          if (m_age > m_resp_age) begin
            m_active = 1'b0; m_ptr = m_owner;
          end
        end else if (m_age >= 2) begin
          if (eng_done) begin
            m_res = eng_result; m_err = 1'b0; m_resp_age = m_age;
          end else if (m_age == TO + 1) begin
            m_res = 8'h00; m_err = 1'b1; m_resp_age = m_age;
          end
        end
      end
    end
  end

  // Event logs used by the directed literal checks.
  int         gq_idx[$], gq_cyc[$], rq_idx[$], rq_cyc[$];
  logic [7:0] gq_data[$], gq_key[$], rq_data[$];
  logic       gq_enc[$], rq_err[$];

  function automatic int oh2idx(logic [N-1:0] v);
    logic [N-1:0] s;
    for (int k = 0; k < N; k++) begin
      s = v >> k;
      if (s[0]) return k;
    end
    return -1;
  endfunction

  logic [N-1:0] e_gnt, e_rv;

  initial forever begin
    @(negedge clk);
    e_gnt = '0;
    e_rv  = '0;
    if (m_active && m_age == 0) e_gnt = N'(1) << m_owner;
    if (m_active && m_resp_age != 0 && m_age == m_resp_age) e_rv = N'(1) << m_owner;
    check("gnt", gnt, e_gnt);
    check("eng_start", eng_start, e_gnt != '0);
    check("resp_valid", resp_valid, e_rv);
    check("busy", busy, m_active);
    if (e_rv != '0) begin
      check("resp_data", resp_data, m_res);
      check("resp_err", resp_err, m_err);
    end
    if (m_active) begin
      check("eng_data", eng_data, m_data);
      check("eng_key", eng_key, m_key);
      check("eng_encrypt", eng_encrypt, m_enc);
    end
    if (rst) begin
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_eng_data", eng_data, 0);
      check("rst_eng_key", eng_key, 0);
      check("rst_eng_encrypt", eng_encrypt, 0);
    end
    if (gnt != '0) begin
      gq_idx.push_back(oh2idx(gnt)); gq_cyc.push_back(cyc);
      gq_data.push_back(eng_data); gq_key.push_back(eng_key); gq_enc.push_back(eng_encrypt);
    end
    if (resp_valid != '0) begin
      rq_idx.push_back(oh2idx(resp_valid)); rq_cyc.push_back(cyc);
      rq_data.push_back(resp_data); rq_err.push_back(resp_err);
    end
  end

  // Requester side: inputs move 2 time units after the rising edge.
  bit           auto_drop = 1'b1;
  logic [N-1:0] last_gnt  = '0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (auto_drop) req = req & ~last_gnt;
    last_gnt = gnt;
  endtask

  task automatic set_req(int i, logic [7:0] d, logic [7:0] k, logic e);
    req_data    = (req_data & ~(BYTE_MASK << (8 * i))) | ((8*N)'(d) << (8 * i));
    req_key     = (req_key & ~(BYTE_MASK << (8 * i))) | ((8*N)'(k) << (8 * i));
    req_encrypt = (req_encrypt & ~(N'(1) << i)) | (N'(e) << i);
    req         = req | (N'(1) << i);
  endtask

  task automatic wait_resp(string name, int budget);
    bit got = 1'b0;
    for (int t = 0; t < budget && !got; t++) begin
      tick();
      if (resp_valid != '0) got = 1'b1;
    end
    check(name, got, 1);
    tick();
  endtask

  task automatic wait_gnt(string name, int budget);
    bit got = 1'b0;
    for (int t = 0; t < budget && !got; t++) begin
      tick();
      if (gnt != '0) got = 1'b1;
    end
    check(name, got, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  int         g0, r0;
  int         exp_o[5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_d[5] = '{8'h1E, 8'hD2, 8'h66, 8'hEE, 8'h1E};

  initial begin
    rst = 1'b1; req = '0; req_data = '0; req_key = '0; req_encrypt = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_gnt", gnt, 0);
    check("reset_resp_valid", resp_valid, 0);

    // 1: single requester, engine done two cycles after start.
    e_delay = 2;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    set_req(2, 8'hA5, 8'h3C, 1'b1);
    wait_resp("t1_resp_seen", 20);
    check("t1_gnt_count", gq_idx.size() - g0, 1);
    check("t1_gnt_owner", gq_idx[g0], 2);
    check("t1_eng_data", gq_data[g0], 8'hA5);
    check("t1_eng_key", gq_key[g0], 8'h3C);
    check("t1_eng_encrypt", gq_enc[g0], 1);
    check("t1_resp_owner", rq_idx[r0], 2);
    check("t1_resp_data", rq_data[r0], 8'h99);
    check("t1_resp_err", rq_err[r0], 0);

    // 2: all requesters held, round-robin from a fresh pointer.
    pulse_reset();
    e_delay = 1; auto_drop = 1'b0;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    set_req(0, 8'h11, 8'h0F, 1'b1);
    set_req(1, 8'h22, 8'hF0, 1'b1);
    set_req(2, 8'h33, 8'h55, 1'b1);
    set_req(3, 8'h44, 8'hAA, 1'b1);
    for (int j = 0; j < 5; j++) wait_resp("t2_resp_seen", 20);
    req = '0; auto_drop = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check("t2_gnt_order", gq_idx[g0 + j], exp_o[j]);
      check("t2_resp_owner", rq_idx[r0 + j], exp_o[j]);
      check("t2_resp_data", rq_data[r0 + j], exp_d[j]);
    end

    // 3: engine never finishes; timeout then a normal job from requester 0.
    e_delay = 0;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    set_req(1, 8'h3C, 8'h77, 1'b1);
    wait_resp("t3_resp_seen", 40);
    check("t3_resp_owner", rq_idx[r0], 1);
    check("t3_resp_err", rq_err[r0], 1);
    check("t3_resp_data", rq_data[r0], 8'h00);
    check("t3_timeout_span", rq_cyc[r0] - gq_cyc[g0], 16);
    e_delay = 1;
    set_req(0, 8'h0F, 8'hF0, 1'b1);
    wait_resp("t3_next_resp_seen", 20);
    check("t3_next_owner", rq_idx[r0 + 1], 0);
    check("t3_next_data", rq_data[r0 + 1], 8'hFF);
    check("t3_next_err", rq_err[r0 + 1], 0);

    // 4: done arrives in the very last wait cycle.
    e_delay = 15; e_force = 1'b1; e_force_val = 8'h5A;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    set_req(1, 8'h12, 8'h34, 1'b1);
    wait_resp("t4_resp_seen", 40);
    e_force = 1'b0;
    check("t4_resp_err", rq_err[r0], 0);
    check("t4_resp_data", rq_data[r0], 8'h5A);
    check("t4_span", rq_cyc[r0] - gq_cyc[g0], 16);

    // 5: reset while waiting; pointer (now 1) must return to its reset value.
    e_delay = 0;
    r0 = rq_idx.size();
    set_req(2, 8'h01, 8'h02, 1'b1);
    wait_gnt("t5_gnt_seen", 10);
    repeat (3) tick();
    rst = 1'b1;
    req = '0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_resp_valid", resp_valid, 0);
    check("t5_rst_eng_start", eng_start, 0);
    check("t5_rst_gnt", gnt, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    check("t5_no_resp", rq_idx.size() - r0, 0);
    e_delay = 1;
    g0 = gq_idx.size();
    set_req(0, 8'hC3, 8'h0F, 1'b1);
    set_req(3, 8'h81, 8'h18, 1'b0);
    wait_resp("t5_resp_a_seen", 20);
    wait_resp("t5_resp_b_seen", 20);
    check("t5_first_gnt", gq_idx[g0], 0);
    check("t5_second_gnt", gq_idx[g0 + 1], 3);
    check("t5_second_data", rq_data[r0 + 1], 8'h99);

    // 6: encrypt then decrypt round trip; a withdrawn request is never granted.
    e_delay = 1;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    set_req(0, 8'hFF, 8'h55, 1'b1);
    wait_resp("t6_enc_resp_seen", 20);
    check("t6_enc_data", rq_data[r0], 8'hAA);
    e_delay = 3;
    set_req(1, 8'hAA, 8'h55, 1'b0);
    wait_gnt("t6_dec_gnt_seen", 10);
    tick();
    set_req(2, 8'h77, 8'h77, 1'b1);
    tick();
    req = req & ~(N'(1) << 2);
    wait_resp("t6_dec_resp_seen", 20);
    repeat (8) tick();
    check("t6_dec_owner", rq_idx[r0 + 1], 1);
    check("t6_dec_data", rq_data[r0 + 1], 8'hFF);
    check("t6_dec_mode", gq_enc[g0 + 1], 0);
    check("t6_gnt_count", gq_idx.size() - g0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
